ws2812b_multi_driver: RTL and testbench
=======================================

# ws2812b_multi_driver

Byte-register TinyQV peripheral that drives up to four WS2812B LED strings from one shared bit serializer. Entries are buffered in a small pixel command FIFO, so the CPU can queue several pixel runs without polling between them. Each run carries its own colour, repeat count, target channel and latch request. Optional RGBW (SK6812-style, 32-bit) pixels are compiled in by macro. The block sits at a TinyQV byte-peripheral slot; its outputs appear on uo_out.

## Interface
- CLK_HZ, 64000000: clock frequency; all pulse widths are derived from it.
- CHANNELS, 2: number of strings, 1..4; channel c drives uo_out[1+c].
- FIFO_DEPTH, 4: command FIFO entries; must be a power of two, 2..8.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- ui_in  in  8  unused.
- uo_out  out  8  [1+c] is the string data for channel c; all other bits are 0.
- address  in  4  register select.
- data_write  in  1  one-cycle write strobe.
- data_in  in  8  write data.
- data_out  out  8  read data; combinational from address.

## Operation
- 0x1 G, 0x2 R, 0x3 B: colour staging registers, read/write.
- 0x4 W: colour staging register; exists only with the macro, otherwise reads 0.
- 0x5 CFG, read/write:
  - [1:0] channel for the next push; values ≥CHANNELS are clamped to CHANNELS-1.
  - [4] 32-bit mode; exists only with the macro.
- 0x0 CTRL write pushes one entry {G,R,B,W, chan, mode, repeat=1+data_in[6:1], latch=data_in[7], black=~data_in[0]}.
  - Push while full: entry dropped, OVERFLOW set. This applies even if a pop happens in the same cycle.
- 0x0 read: {7'b0, ~full}.
- 0x6 STATUS read: {count[3:0], 1'b0, OVERFLOW, idle, ~full}.
  - idle = FIFO empty and serializer idle.
  - Writing 0x6 with data_in[2]=1 clears OVERFLOW.
- All other addresses read 0; writes to them are ignored.
- Dispatcher FSM states: IDLE → LOAD → SEND → (LATCH) → IDLE.
  - IDLE: a non-empty FIFO pops the head into a working register in LOAD.
  - SEND: emits the pixel repeat times. Pixel = 24 bits G,R,B (or 32 bits with W appended), MSB first. A black entry sends zeros.
  - LATCH: entered only if latch=1. Holds the line low for T_RES, then returns to IDLE.
- Line output: only the entry's channel pin toggles. Other pins are held 0.
- Staging registers are unaffected by pushes. A later push reuses the old colour unless it is rewritten.
- Reset: FIFO is emptied, OVERFLOW=0, CFG=0, colours=0, FSM=IDLE, all uo_out=0, data_out reflects ~full=1.

## Timing
- Derived cycle counts, rounded to nearest: T_BIT=CLK_HZ·1.25µs, T0H=·0.4µs, T1H=·0.8µs, T_RES=·80µs.
  - At 64 MHz: 80, 26, 51, 5120.
- Bit timing: high for T0H or T1H cycles, then low for the rest of T_BIT. Bits are back-to-back with no gap, including across repeats and across consecutive entries on the same channel.
- Push latency: the push is visible in count the cycle after the write. The first rising edge on the pin follows at most 3 cycles after that, when the block was idle.
- Pop occurs in LOAD, so ~full rises one cycle after LOAD.
- Channel change between entries: there is no gap; the new pin starts at the next bit slot.
- Reset asserted mid-bit: the pin goes low on the next edge, with no partial-frame completion.

## Configuration
- WS2812B_RGBW_EN defined:
  - W register exists and CFG[4] exists.
  - FIFO entries are 32-bit colour + mode.
  - Entries with mode=1 send 32 bits.
- WS2812B_RGBW_EN undefined:
  - W register and CFG[4] read 0 and ignore writes.
  - Entries are 24-bit; only 24-bit pixels are sent.

## Structure
- Package ws2812b_multi_pkg holds:
  - register address constants;
  - the STATUS bit positions;
  - the FSM state enum;
  - the entry struct type;
  - the timing-count functions of CLK_HZ.
- Sub-module ws2812b_bit_serializer takes a parallel pixel plus a bit count and handles the valid/ready handshake and bit timing. The dispatcher, FIFO and register file stay in the top module.

## Test plan
- G=0xFF, R=0x00, B=0x81, CTRL=0x81 (repeat 1, latch, colour):
  - exactly 24 bits on uo_out[1], with high times 51×8, 26×8, 51, 26×6, 51;
  - then 5120 low cycles;
  - idle=1 afterwards.
- CTRL=0x06 (repeat 4, black, no latch): 96 bits, all with 26-cycle highs, and no latch low period.
- CFG=1, then push: only uo_out[2] toggles; uo_out[1] stays 0.
- Five pushes with DEPTH=4 while busy:
  - the fifth is dropped, OVERFLOW=1, count=4;
  - writing 0x04 to 0x6 clears OVERFLOW.
- rst_n low mid-pixel: the next cycle has all outputs 0, count=0, and STATUS=0x01.
- With WS2812B_RGBW_EN, CFG=0x10, W=0x0F: 32 bits are sent, with the last byte's high times 26×4, 51×4.

Source files
------------

// File: rtl/ws2812b_multi_pkg.sv
// Shared constants, types and timing helpers for the WS2812B multi-string driver.
// WS2812B_RGBW_EN widens FIFO entries to 32-bit colour for SK6812-style pixels.
package ws2812b_multi_pkg;

  localparam logic [3:0] AddrCtrl   = 4'h0;
  localparam logic [3:0] AddrG      = 4'h1;
  localparam logic [3:0] AddrR      = 4'h2;
  localparam logic [3:0] AddrB      = 4'h3;
  localparam logic [3:0] AddrW      = 4'h4;
  localparam logic [3:0] AddrCfg    = 4'h5;
  localparam logic [3:0] AddrStatus = 4'h6;

  localparam int unsigned StatNotFull  = 0;
  localparam int unsigned StatIdle     = 1;
  localparam int unsigned StatOverflow = 2;
  localparam int unsigned StatClrBit   = 2;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StLatch} disp_state_e;

`ifdef WS2812B_RGBW_EN
  localparam int unsigned ColorW = 32;
`else
  localparam int unsigned ColorW = 24;
`endif

  typedef struct packed {
    logic [ColorW-1:0] color;
    logic [1:0]        chan;
    logic              mode;
    logic [5:0]        rep;    // repeat count minus one
    logic              latch;
    logic              black;
  } entry_t;

  // Cycle count for a duration in ns, rounded to nearest.
  function automatic int unsigned cycles_ns(int unsigned clk_hz, int unsigned ns);
    longint unsigned prod;
    prod = 64'(clk_hz) * 64'(ns) + 64'd500_000_000;
    return 32'(prod / 64'd1_000_000_000);
  endfunction

  function automatic int unsigned t_bit(int unsigned clk_hz);
    return cycles_ns(clk_hz, 1250);
  endfunction

  function automatic int unsigned t0h(int unsigned clk_hz);
    return cycles_ns(clk_hz, 400);
  endfunction

  function automatic int unsigned t1h(int unsigned clk_hz);
    return cycles_ns(clk_hz, 800);
  endfunction

  function automatic int unsigned t_res(int unsigned clk_hz);
    return cycles_ns(clk_hz, 80000);
  endfunction

endpackage

// File: rtl/ws2812b_bit_serializer.sv
// Shifts a parallel pixel out MSB first as WS2812B bit pulses on one of four lines.
// Accepts the next pixel in the last cycle of the final bit so pixels run back-to-back.
module ws2812b_bit_serializer #(
  parameter int unsigned T_BIT = 80,
  parameter int unsigned T0H   = 26,
  parameter int unsigned T1H   = 51
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [31:0] pixel,
  input  logic [5:0]  nbits,
  input  logic [1:0]  chan,
  output logic        ready,
  output logic        busy,
  output logic [3:0]  line
);

  localparam logic [15:0] TBitM1 = 16'(T_BIT - 1);
  localparam logic [15:0] T0h    = 16'(T0H);
  localparam logic [15:0] T1h    = 16'(T1H);

  logic        busy_q;
  logic [31:0] shift_q;
  logic [5:0]  left_q;
  logic [15:0] cnt_q;
  logic [1:0]  chan_q;
  logic [3:0]  line_q;
  logic        last_slot;
  logic [15:0] hi_len;

  assign last_slot = busy_q && (cnt_q == TBitM1);
  assign ready     = !busy_q || (last_slot && (left_q == 6'd1));
  assign hi_len    = shift_q[31] ? T1h : T0h;
  assign busy      = busy_q;
  assign line      = line_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      shift_q <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
      chan_q  <= '0;
      line_q  <= '0;
    end else if (valid && ready) begin
      busy_q  <= 1'b1;
      shift_q <= pixel;
      left_q  <= nbits;
      cnt_q   <= '0;
      chan_q  <= chan;
      line_q  <= 4'b0001 << chan;
    end else if (busy_q) begin
      if (cnt_q == TBitM1) begin
        cnt_q <= '0;
        if (left_q == 6'd1) begin
          busy_q <= 1'b0;
          line_q <= '0;
        end else begin
          left_q  <= left_q - 6'd1;
          shift_q <= shift_q << 1;
          line_q  <= 4'b0001 << chan_q;
        end
      end else begin
        cnt_q  <= cnt_q + 16'd1;
        line_q <= ((cnt_q + 16'd1) < hi_len) ? (4'b0001 << chan_q) : 4'b0000;
      end
    end
  end

endmodule

// File: rtl/ws2812b_multi_driver.sv
// TinyQV byte peripheral: register file, pixel command FIFO and dispatcher feeding
// one shared bit serializer. Define WS2812B_RGBW_EN for the W register and 32-bit mode.
module ws2812b_multi_driver
  import ws2812b_multi_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 64000000,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned TRes = t_res(CLK_HZ);
  localparam int unsigned LatW = $clog2(TRes + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [1:0]  ChanMax = 2'(CHANNELS - 1);

  logic [7:0] g_q, r_q, b_q, w_val;
  logic [1:0] cfg_chan_q;
  logic       mode_val, ovf_q, idle_q;
  entry_t     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] count_q;
  logic       full, push, push_ok, pop;
  entry_t     push_entry;
  logic       unused_ui;

  disp_state_e     state_q;
  entry_t          work_q;
  logic [6:0]      left_q;
  logic [LatW-1:0] lat_cnt_q;
  logic            ser_valid, ser_ready, ser_busy;
  logic [31:0]     ser_pixel;
  logic [5:0]      ser_nbits;
  logic [3:0]      ser_line;

  assign unused_ui = ^ui_in;

`ifdef WS2812B_RGBW_EN
  logic [7:0] w_q;
  logic       mode_q;
  assign w_val    = w_q;
  assign mode_val = mode_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q    <= '0;
      mode_q <= 1'b0;
    end else if (data_write && address == AddrW) begin
      w_q <= data_in;
    end else if (data_write && address == AddrCfg) begin
      mode_q <= data_in[4];
    end
  end
`else
  assign w_val    = '0;
  assign mode_val = 1'b0;
`endif

  assign full    = (count_q == 4'(FIFO_DEPTH));
  assign push    = data_write && (address == AddrCtrl);
  assign push_ok = push && !full;   // a same-cycle pop never makes room
  assign pop     = (state_q == StLoad);

  always_comb begin
    push_entry       = '0;
`ifdef WS2812B_RGBW_EN
    push_entry.color = {g_q, r_q, b_q, w_val};
`else
    push_entry.color = {g_q, r_q, b_q};
`endif
    push_entry.chan  = (cfg_chan_q > ChanMax) ? ChanMax : cfg_chan_q;
    push_entry.mode  = mode_val;
    push_entry.rep   = data_in[6:1];
    push_entry.latch = data_in[7];
    push_entry.black = ~data_in[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_q        <= '0;
      r_q        <= '0;
      b_q        <= '0;
      cfg_chan_q <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (data_write) begin
        case (address)
          AddrG:      g_q <= data_in;
          AddrR:      r_q <= data_in;
          AddrB:      b_q <= data_in;
          AddrCfg:    cfg_chan_q <= data_in[1:0];
          AddrStatus: if (data_in[StatClrBit]) ovf_q <= 1'b0;
          AddrCtrl:   if (full) ovf_q <= 1'b1;
          default:    ;
        endcase
      end
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + 4'(push_ok) - 4'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      work_q    <= '0;
      left_q    <= '0;
      lat_cnt_q <= '0;
      idle_q    <= 1'b0;
    end else begin
      idle_q <= (count_q == 4'd0) && (state_q == StIdle) && !ser_busy;
      case (state_q)
        StIdle: if (count_q != 4'd0) state_q <= StLoad;
        StLoad: begin
          work_q  <= fifo_q[rd_ptr_q];
          left_q  <= {1'b0, fifo_q[rd_ptr_q].rep} + 7'd1;
          state_q <= StSend;
        end
        StSend: begin
          if (ser_ready) begin
            left_q <= left_q - 7'd1;
            if (left_q == 7'd1) state_q <= work_q.latch ? StLatch : StIdle;
          end
        end
        StLatch: begin
          // Reset time counts only once the final bit has fully left the serializer.
          if (ser_busy) begin
            lat_cnt_q <= '0;
          end else if (lat_cnt_q == LatW'(TRes - 1)) begin
            state_q <= StIdle;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ser_valid = (state_q == StSend);
  assign ser_nbits = work_q.mode ? 6'd32 : 6'd24;

  always_comb begin
`ifdef WS2812B_RGBW_EN
    ser_pixel = work_q.mode ? work_q.color : {work_q.color[31:8], 8'h00};
`else
    ser_pixel = {work_q.color, 8'h00};
`endif
    if (work_q.black) ser_pixel = '0;
  end

  ws2812b_bit_serializer #(
    .T_BIT (t_bit(CLK_HZ)),
    .T0H   (t0h(CLK_HZ)),
    .T1H   (t1h(CLK_HZ))
  ) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (ser_valid),
    .pixel (ser_pixel),
    .nbits (ser_nbits),
    .chan  (work_q.chan),
    .ready (ser_ready),
    .busy  (ser_busy),
    .line  (ser_line)
  );

  always_comb begin
    uo_out = '0;
    for (int c = 0; c < int'(CHANNELS); c++) uo_out[1+c] = ser_line[c];
  end

  always_comb begin
    case (address)
      AddrCtrl:   data_out = {7'b0, ~full};
      AddrG:      data_out = g_q;
      AddrR:      data_out = r_q;
      AddrB:      data_out = b_q;
      AddrW:      data_out = w_val;
      AddrCfg:    data_out = {3'b0, mode_val, 2'b0, cfg_chan_q};
      AddrStatus: data_out = {count_q, 1'b0, ovf_q, idle_q, ~full};
      default:    data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_ws2812b_multi_driver.sv
// Directed plus randomized bench: captures every pulse per pin and compares the
// pulse train against a pixel-level reference model of queued entries.
module tb_ws2812b_multi_driver;

  localparam int CHANNELS = 2;
  localparam int TBIT = 80;
  localparam int T0H = 26;
  localparam int T1H = 51;
  localparam int TRES = 5120;
  localparam logic [7:0] StrayMask = ~8'(((1 << CHANNELS) - 1) << 1);

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] ui_in, uo_out, data_in, data_out;
  logic [3:0] address;
  logic data_write;

  ws2812b_multi_driver #(
    .CLK_HZ     (64000000),
    .CHANNELS   (CHANNELS),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {int chan; int start; int len;} pulse_t;
  pulse_t pq[$];
  pulse_t eq[$];

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  bit stray = 0;
  bit prev_pin [4] = '{default: 0};
  int hi_start [4];
  int hi_len [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((uo_out & StrayMask) != 8'h00) stray = 1;
    for (int c = 0; c < 4; c++) begin
      if (uo_out[1+c]) begin
        if (!prev_pin[c]) begin
          hi_start[c] = cyc;
          hi_len[c] = 0;
        end
        hi_len[c]++;
      end else if (prev_pin[c]) begin
        pq.push_back('{c, hi_start[c], hi_len[c]});
      end
      prev_pin[c] = uo_out[1+c];
    end
  end

  // Reference model state: staging registers as the CPU last wrote them.
  logic [7:0] m_g, m_r, m_b, m_w, m_cfg;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected range %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic set_colour(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    write_reg(4'h1, g);
    write_reg(4'h2, r);
    write_reg(4'h3, b);
    m_g = g;
    m_r = r;
    m_b = b;
  endtask

  // Push a CTRL byte and append the pulses the entry should produce.
  task automatic push(input logic [7:0] ctrl);
    int rep, nb, chan;
    logic [31:0] pix;
    write_reg(4'h0, ctrl);
    rep = int'(ctrl[6:1]) + 1;
    chan = (int'(m_cfg[1:0]) > CHANNELS - 1) ? CHANNELS - 1 : int'(m_cfg[1:0]);
`ifdef WS2812B_RGBW_EN
    nb = m_cfg[4] ? 32 : 24;
    pix = {m_g, m_r, m_b, m_w};
`else
    nb = 24;
    pix = {m_g, m_r, m_b, 8'h00};
`endif
    for (int k = 0; k < rep; k++)
      for (int i = 0; i < nb; i++)
        eq.push_back('{chan, 0, (ctrl[0] && pix[31-i]) ? T1H : T0H});
  endtask

  task automatic wait_idle(output int t);
    logic [7:0] s;
    bit seen;
    seen = 0;
    t = cyc;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 40000 && !seen; i++) begin
      @(negedge clk);
      read_reg(4'h6, s);
      if (s[1]) begin
        seen = 1;
        t = cyc;
      end
    end
    chk("idle_timeout", int'(seen), 1);
  endtask

  task automatic check_run(input string tag, input bit gapless);
    int n, bl, bc, bg;
    n = (pq.size() < eq.size()) ? pq.size() : eq.size();
    bl = -1;
    bc = -1;
    bg = -1;
    chk({tag, "_count"}, pq.size(), eq.size());
    for (int i = 0; i < n; i++) begin
      if (bl < 0 && pq[i].len != eq[i].len) bl = i;
      if (bc < 0 && pq[i].chan != eq[i].chan) bc = i;
      if (bg < 0 && i > 0 && pq[i].start - pq[i-1].start != TBIT) bg = i;
    end
    if (n > 0) begin
      if (bl < 0) bl = 0;
      if (bc < 0) bc = 0;
      chk({tag, "_high"}, pq[bl].len, eq[bl].len);
      chk({tag, "_chan"}, pq[bc].chan, eq[bc].chan);
      if (gapless && n > 1) begin
        if (bg < 0) bg = 1;
        chk({tag, "_slot"}, pq[bg].start - pq[bg-1].start, TBIT);
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    int t, push_cyc;
    rst_n = 1'b0;
    ui_in = 8'h00;
    address = 4'h0;
    data_in = 8'h00;
    data_write = 1'b0;
    m_g = 0; m_r = 0; m_b = 0; m_w = 0; m_cfg = 0;

    repeat (3) @(negedge clk);
    chk("rst_uo_out", int'(uo_out), 0);
    read_reg(4'h0, d); chk("rst_notfull", int'(d), 1);
    read_reg(4'h6, d); chk("rst_status", int'(d), 8'h01);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    read_reg(4'h6, d); chk("idle_status", int'(d), 8'h03);
    read_reg(4'h5, d); chk("rst_cfg", int'(d), 0);

    // Coloured pixel with latch.
    set_colour(8'hFF, 8'h00, 8'h81);
    read_reg(4'h3, d); chk("readback_b", int'(d), 8'h81);
    pq.delete(); eq.delete();
    push(8'h81);
    push_cyc = cyc;
    read_reg(4'h6, d); chk("push_count", int'(d[7:4]), 1);
    wait_idle(t);
    check_run("latch_px", 1);
    if (pq.size() > 0) begin
      chk_rng("push_latency", pq[0].start - push_cyc, 1, 3);
      chk_rng("latch_low", t - (pq[pq.size()-1].start + TBIT), TRES, TRES + 4);
    end

    // Black, repeat 4, no latch.
    pq.delete(); eq.delete();
    push(8'h06);
    wait_idle(t);
    check_run("black_x4", 1);
    if (pq.size() > 0) chk_rng("no_latch", t - (pq[pq.size()-1].start + TBIT), 0, 4);

    // Channel 1 reusing old staging colour.
    write_reg(4'h5, 8'h01);
    m_cfg = 8'h01;
    pq.delete(); eq.delete();
    push(8'h01);
    wait_idle(t);
    check_run("chan1", 1);

    // Random entries on random (possibly clamped) channels, queued back-to-back.
    pq.delete(); eq.delete();
    for (int k = 0; k < 4; k++) begin
      set_colour(8'($urandom), 8'($urandom), 8'($urandom));
      m_cfg = 8'($urandom_range(0, 3));
      write_reg(4'h5, m_cfg);
      push({1'b0, 6'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
    end
    wait_idle(t);
    check_run("random", 1);

    // Overflow: one long entry in flight, then five pushes.
    push(8'h7F);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5; k++) write_reg(4'h0, 8'h01);
    read_reg(4'h6, d); chk("ovf_status", int'(d), 8'h44);
    read_reg(4'h0, d); chk("full_ctrl", int'(d), 0);
    write_reg(4'h6, 8'h04);
    read_reg(4'h6, d); chk("ovf_clear", int'(d[2]), 0);

    // Reset mid-pixel.
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_uo_out", int'(uo_out), 0);
    read_reg(4'h6, d); chk("midrst_status", int'(d), 8'h01);
    rst_n = 1'b1;
    m_g = 0; m_r = 0; m_b = 0; m_w = 0; m_cfg = 0;
    repeat (2) @(negedge clk);
    pq.delete(); eq.delete();

`ifdef WS2812B_RGBW_EN
    set_colour(8'($urandom), 8'($urandom), 8'($urandom));
    write_reg(4'h4, 8'h0F);
    m_w = 8'h0F;
    write_reg(4'h5, 8'h10);
    m_cfg = 8'h10;
    read_reg(4'h5, d); chk("cfg_mode", int'(d), 8'h10);
    push(8'h01);
    wait_idle(t);
    check_run("rgbw", 1);
`else
    write_reg(4'h4, 8'h5A);
    read_reg(4'h4, d); chk("w_absent", int'(d), 0);
    write_reg(4'h5, 8'h10);
    read_reg(4'h5, d); chk("mode_absent", int'(d), 0);
`endif

    chk("stray_pins", int'(stray), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
